e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//   Execute-stage multiply/divide unit. Holds the architectural HI/LO registers.
//   Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations.
//   Sits beside the ALU, fed by the D->E pipeline register's decoded op and operands.
//   The hazard unit uses stall_req to freeze D/E while an op is in flight.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (legal range 1..15)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (legal range 1..15)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   reset      in   1   reset, synchronous, active-high
//   start      in   1   E-stage instr is an MDU op this cycle
//   mdu_op     in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved
//   rs_val     in   32  forwarded rs operand (dividend / multiplicand / MT source)
//   rt_val     in   32  forwarded rt operand (divisor / multiplier)
//   busy       out  1   registered; high while a mult/div is in flight
//   stall_req  out  1   comb: busy | (start & mdu_op in 1..4)
//   hi         out  32  architectural HI (registered)
//   lo         out  32  architectural LO (registered)
// BEHAVIOUR
//   - Reset: hi=0, lo=0, busy=0, internal counter=0, pending result cleared.
//     Reset mid-operation aborts the op; no HI/LO write occurs.
//   - Launch: at a posedge with start=1, busy=0 and mdu_op in 1..4:
//     - Compute the result from rs_val/rt_val and hold it internally.
//     - Load the counter with N (MULT_CYCLES or DIV_CYCLES).
//     - busy=1 from the next cycle.
//   - Countdown:
//     - busy stays high for exactly N cycles; counter decrements each edge.
//     - On the edge that ends the Nth busy cycle, HI/LO take the pending result and busy falls.
//     - New HI/LO are visible in the first cycle with busy=0.
//   - Back-to-back: a launch is accepted in the first cycle busy=0. There is no overlap.
//   - MTHI/MTLO: at a posedge with start=1, busy=0 and op 5/6, write rs_val to hi/lo.
//     Latency 1; busy remains 0.
//   - Ignored inputs (no state change):
//     - start=1 while busy=1, for any op; the hazard unit must stall.
//     - mdu_op 0 or 7, regardless of start.
//     - Any op with start=0.
//   - Arithmetic:
//     - MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
//     - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
//     - DIV overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//     - DIVU: unsigned quotient in lo, remainder in hi.
//     - Divide by zero (DIV or DIVU): busy for full DIV_CYCLES, then hi/lo unchanged.
//   - stall_req is high in the launch cycle and every busy cycle, and low otherwise.
//     This covers MFHI/MFLO interlock.
// TESTING
//   1. MULT rs=3, rt=0xFFFFFFFE:
//      -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   2. MULTU 0xFFFFFFFF*0xFFFFFFFF:
//      -> hi=0xFFFFFFFE, lo=0x00000001; stall_req=1 in the launch cycle.
//   3. DIV -7/2:
//      -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIVU 7/0 with hi=0x11, lo=0x22:
//      -> busy 10 cycles; hi/lo stay 0x11/0x22.
//   4. MULT 2*3, then MTHI rs=0xAAAA applied while busy:
//      -> ignored; final hi=0, lo=6.
//      MTLO 0x55 when idle:
//      -> lo=0x55 next cycle, busy=0.
//   5. DIV 100/7, reset asserted in busy cycle 3:
//      -> next cycle busy=0, hi=lo=0; no late write afterwards.
//   6. MULT 4*5, then DIVU 9/4 launched in the first busy=0 cycle:
//      -> lo=20; then after 10 more cycles lo=2, hi=1.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding architectural HI/LO.
// Ports: clk, reset (sync, active-high); start/mdu_op/rs_val/rt_val in;
// busy, stall_req, hi, lo out. Ops run a fixed number of busy cycles.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        pwe_q, pwe_d;

  logic        idle;
  logic        is_md;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] b_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  assign idle      = (state_q == S_IDLE);
  assign is_md     = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
  assign busy      = (state_q == S_BUSY);
  assign stall_req = busy | (start & is_md);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Truncated product of sign-extended operands is the signed product.
  assign prod_s = {{32{rs_val[31]}}, rs_val}
                * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes; remainder follows the dividend.
  // 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
  assign sgn      = (mdu_op == OP_DIV);
  assign a_neg    = sgn & rs_val[31];
  assign b_neg    = sgn & rt_val[31];
  assign a_abs    = a_neg ? -rs_val : rs_val;
  assign b_abs    = b_neg ? -rt_val : rt_val;
  assign div_zero = (rt_val == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_abs;
  assign q_u      = a_abs / b_safe;
  assign r_u      = a_abs % b_safe;
  assign quo      = (a_neg ^ b_neg) ? -q_u : q_u;
  assign rem      = a_neg ? -r_u : r_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwe_d   = pwe_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (mdu_op)
            OP_MULT: begin
              state_d = S_BUSY;
              cnt_d   = MC;
              {phi_d, plo_d} = prod_s;
              pwe_d   = 1'b1;
            end
            OP_MULTU: begin
              state_d = S_BUSY;
              cnt_d   = MC;
              {phi_d, plo_d} = prod_u;
              pwe_d   = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_BUSY;
              cnt_d   = DC;
              phi_d   = rem;
              plo_d   = quo;
              // Divide by zero burns the cycles but leaves HI/LO alone.
              pwe_d   = ~div_zero;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (pwe_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwe_q   <= pwe_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors for e_mdu; results checked by a
// scoreboard monitor that fires whenever busy falls.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   bcnt = 0;
  logic busy_prev = 1'b0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: count busy cycles, compare on the falling edge of busy.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      bcnt++;
    end else if (busy_prev === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: result with no expected entry");
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_busy_cycles", 32'(bcnt), 32'(e.ncyc));
      end
      bcnt = 0;
    end
    busy_prev = busy;
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l,
                      input int n);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.ncyc = n;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit cs,
                       input logic req_stall);
    start  = 1'b1;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    #1;
    if (cs) chk("stall_req_launch", {31'd0, stall_req}, {31'd0, req_stall});
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) return;
      @(posedge clk);
      #1;
    end
    chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("idle_stall", {31'd0, stall_req}, 32'd0);

    // MULT 3 * -2
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(3'd1, 32'd3, 32'hFFFF_FFFE, 1'b1, 1'b1);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    chk("stall_busy", {31'd0, stall_req}, 32'd1);
    wait_idle();

    // MULTU max * max
    push(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    // DIV -7 / 2
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_idle();

    // MTHI/MTLO then DIVU by zero keeps them
    issue(3'd5, 32'h11, 32'd0, 1'b1, 1'b0);
    issue(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);
    push(32'h11, 32'h22, 10);
    issue(3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    wait_idle();

    // DIV 7 / -2, and overflow case
    push(32'd1, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_idle();
    push(32'd0, 32'h8000_0000, 10);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle();

    // MULT 2*3 with MTHI while busy (ignored)
    push(32'd0, 32'd6, 5);
    issue(3'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    issue(3'd5, 32'hAAAA, 32'd0, 1'b0, 1'b0);
    chk("mthi_busy_ignored", hi, 32'd0);
    chk("mthi_busy_still", {31'd0, busy}, 32'd1);
    wait_idle();

    // MTLO idle, then ignored inputs
    issue(3'd6, 32'h55, 32'd0, 1'b0, 1'b0);
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    mdu_op = 3'd6;
    rs_val = 32'h77;
    @(posedge clk);
    #1;
    issue(3'd7, 32'h99, 32'd1, 1'b1, 1'b0);
    issue(3'd0, 32'h99, 32'd1, 1'b0, 1'b0);
    chk("ign_lo", lo, 32'h55);
    chk("ign_hi", hi, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd0);

    // DIV 100/7, reset in busy cycle 3
    push(32'd0, 32'd0, 3);
    issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_hi", hi, 32'd0);

    // MULT 4*5 then back-to-back DIVU 9/4
    push(32'd0, 32'd20, 5);
    push(32'd1, 32'd2, 10);
    issue(3'd1, 32'd4, 32'd5, 1'b0, 1'b0);
    wait_idle();
    chk("b2b_lo", lo, 32'd20);
    issue(3'd4, 32'd9, 32'd4, 1'b1, 1'b1);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
